// File: rtl/mem_stage_pkg.sv
// Shared types for the MEM pipeline stage: FSM state encoding and MEM/WB field bundle.
// Optional performance counters in mem_stage_unit are enabled with MEM_STAGE_PERF_EN.
package mem_stage_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_REG_W  = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } mem_state_t;

  // Field widths follow the package defaults; the top-level widths must match them.
  typedef struct packed {
    logic                  wbs;
    logic                  mm;
    logic                  ni;
    logic                  wme;
    logic [DEF_DATA_W-1:0] alu_result;
    logic [DEF_DATA_W-1:0] load_data;
    logic [DEF_REG_W-1:0]  reg_dest;
    logic [DEF_REG_W-1:0]  reg_dest_wb;
  } memwb_fields_t;

endpackage

// File: rtl/mem_wait_timer.sv
// Saturating response-wait counter; o_expired flags the cycle whose increment reaches MAX_WAIT.
module mem_wait_timer #(
  parameter int MAX_WAIT = 15,
  parameter int CNT_W    = $clog2(MAX_WAIT + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  input  logic i_en,
  output logic o_expired
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MAX_WAIT);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(MAX_WAIT - 1);

  logic [CNT_W-1:0] r_count;

  // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_en && (r_count != LIMIT)) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign o_expired = i_en & (r_count >= LAST);

endmodule

// File: rtl/mem_stage_unit.sv
// MEM pipeline stage: issues data-memory requests, stalls upstream while busy, registers MEM/WB.
// Define MEM_STAGE_PERF_EN to add access and stall performance counters.
module mem_stage_unit
  import mem_stage_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int REG_W    = DEF_REG_W,
  parameter int MAX_WAIT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid_in,
  input  logic              wbs_in,
  input  logic              ni_in,
  input  logic              wme_in,
  input  logic              mm_in,
  input  logic              wm_in,
  input  logic [DATA_W-1:0] alu_result_in,
  input  logic [DATA_W-1:0] store_data_in,
  input  logic [REG_W-1:0]  reg_dest_in,
  input  logic [REG_W-1:0]  reg_dest_data_writeback_in,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_we,
  output logic [DATA_W-1:0] mem_req_addr,
  output logic [DATA_W-1:0] mem_req_wdata,
  input  logic              mem_rsp_valid,
  input  logic [DATA_W-1:0] mem_rsp_data,
  output logic              stall_out,
  output logic              wb_valid_out,
  output logic              wbs_out,
  output logic              mm_out,
  output logic              ni_out,
  output logic              wme_out,
  output logic [DATA_W-1:0] alu_result_out,
  output logic [DATA_W-1:0] load_data_out,
  output logic [REG_W-1:0]  reg_dest_out,
  output logic [REG_W-1:0]  reg_dest_data_writeback_out,
`ifdef MEM_STAGE_PERF_EN
  output logic [31:0]       perf_access_cnt,
  output logic [31:0]       perf_stall_cnt,
`endif
  output logic              mem_err_out
);

  mem_state_t    r_state;
  logic          r_we;
  logic [DATA_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  memwb_fields_t r_held;
  memwb_fields_t r_out;
  logic          r_wb_valid;
  logic          r_err;

  memwb_fields_t w_in_fields;
  logic          w_mem_op;
  logic          w_conflict;
  logic          w_store_done;
  logic          w_load_acc;
  logic          w_rsp_done;
  logic          w_timer_en;
  logic          w_expired;
  logic          w_timeout;
  logic          w_completing;
  logic          w_busy;

  assign w_mem_op   = ex_valid_in & (mm_in | wm_in);
  assign w_conflict = ex_valid_in & mm_in & wm_in;

  // Store wins over a simultaneous load, so the load flag is dropped from the bundle.
  always_comb begin
    // NOTE: default every field first so no path through this block can infer a latch.
    w_in_fields             = '0;
    w_in_fields.wbs         = wbs_in;
    w_in_fields.mm          = mm_in & ~wm_in;
    w_in_fields.ni          = ni_in;
    w_in_fields.wme         = wme_in;
    w_in_fields.alu_result  = alu_result_in;
    w_in_fields.reg_dest    = reg_dest_in;
    w_in_fields.reg_dest_wb = reg_dest_data_writeback_in;
  end

  assign w_store_done = (r_state == REQ) & mem_req_ready & r_we;
  assign w_load_acc   = (r_state == REQ) & mem_req_ready & ~r_we;
  assign w_rsp_done   = (r_state == WAIT) & mem_rsp_valid;
  assign w_timer_en   = (r_state == WAIT) & ~mem_rsp_valid;
  assign w_timeout    = w_expired;
  assign w_completing = w_store_done | w_rsp_done | w_timeout;
  assign w_busy       = (r_state == IDLE) ? w_mem_op : 1'b1;

  mem_wait_timer #(
    .MAX_WAIT (MAX_WAIT)
  ) u_wait_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_clear   (w_load_acc),
    .i_en      (w_timer_en),
    .o_expired (w_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_held     <= '0;
      r_out      <= '0;
      r_wb_valid <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_wb_valid <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_mem_op) begin
            r_state <= REQ;
            r_we    <= wm_in;
            r_addr  <= alu_result_in;
            r_wdata <= store_data_in;
            r_held  <= w_in_fields;
            if (w_conflict) r_err <= 1'b1;
          end else begin
            r_wb_valid <= ex_valid_in;
            r_out      <= w_in_fields;
          end
        end
        REQ: begin
          if (mem_req_ready) begin
            if (r_we) begin
              r_state    <= IDLE;
              r_wb_valid <= 1'b1;
              r_out      <= r_held;
            end else begin
              r_state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (mem_rsp_valid) begin
            r_state         <= IDLE;
            r_wb_valid      <= 1'b1;
            r_out           <= r_held;
            r_out.load_data <= mem_rsp_data;
          end else if (w_timeout) begin
            r_state    <= IDLE;
            r_wb_valid <= 1'b1;
            r_out      <= r_held;
            r_err      <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign mem_req_valid = (r_state == REQ);
  assign mem_req_we    = r_we;
  assign mem_req_addr  = r_addr;
  assign mem_req_wdata = r_wdata;

  // Gated by rst_n so stall reads 0 during reset even while EX/MEM still shows a memory op.
  assign stall_out = rst_n & w_busy & ~w_completing;

  assign wb_valid_out                = r_wb_valid;
  assign wbs_out                     = r_out.wbs;
  assign mm_out                      = r_out.mm;
  assign ni_out                      = r_out.ni;
  assign wme_out                     = r_out.wme;
  assign alu_result_out              = r_out.alu_result;
  assign load_data_out               = r_out.load_data;
  assign reg_dest_out                = r_out.reg_dest;
  assign reg_dest_data_writeback_out = r_out.reg_dest_wb;
  assign mem_err_out                 = r_err;

`ifdef MEM_STAGE_PERF_EN
  logic [31:0] r_perf_access;
  logic [31:0] r_perf_stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_access <= '0;
      r_perf_stall  <= '0;
    end else begin
      if (w_completing) r_perf_access <= r_perf_access + 32'd1;
      if (stall_out)    r_perf_stall  <= r_perf_stall + 32'd1;
    end
  end

  assign perf_access_cnt = r_perf_access;
  assign perf_stall_cnt  = r_perf_stall;
`else
  // Counters absent: completion and stall drive only the pipeline itself.
`endif

endmodule
